// File: rtl/number_stream_tx.sv
// Operand stream transmitter: buffers up to DEPTH words over a load port and
// replays them in write order on a valid/ready stream, marking the final word.
module number_stream_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESETZ,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  input  logic             START,
  output logic             TX_VALID,
  output logic [WIDTH-1:0] TX_DATA,
  output logic             TX_LAST,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] LEVEL
);
  localparam int               AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_cnt, rd_ptr, rd_nxt;
  logic             accept, go;

  assign LOAD_READY = (state == IDLE) && (wr_cnt < FULL);
  assign accept     = LOAD_VALID && LOAD_READY;
  assign go         = START && ((wr_cnt != '0) || accept);
  assign rd_nxt     = rd_ptr + ONE;
  assign BUSY       = (state == SEND);
  assign LEVEL      = wr_cnt;

  // storage has no reset; only wr_cnt defines which entries are live
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_cnt[AW-1:0]] <= LOAD_DATA;
  end

  always_ff @(posedge CLK or negedge RESETZ) begin
    if (!RESETZ) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      TX_VALID <= 1'b0;
      TX_DATA  <= '0;
      TX_LAST  <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) wr_cnt <= wr_cnt + ONE;
          if (go) begin
            state    <= SEND;
            rd_ptr   <= '0;
            TX_VALID <= 1'b1;
            // an empty buffer can only start through a same-cycle load, so
            // the first word bypasses the not-yet-written memory
            TX_DATA  <= (wr_cnt == '0) ? LOAD_DATA : mem[0];
            TX_LAST  <= (wr_cnt == '0) || ((wr_cnt == ONE) && !accept);
          end
        end
        SEND: begin
          if (TX_READY) begin
            if (TX_LAST) begin
              state    <= FIN;
              TX_VALID <= 1'b0;
              TX_LAST  <= 1'b0;
              DONE     <= 1'b1;
            end else begin
              rd_ptr  <= rd_nxt;
              TX_DATA <= mem[rd_nxt[AW-1:0]];
              TX_LAST <= (rd_nxt == wr_cnt - ONE);
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          wr_cnt <= '0;
          rd_ptr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
